// File: rtl/nibble_serial_addsub_if.sv
// Handshake and operand/result bundle for the digit-serial adder/subtractor.
interface nibble_serial_addsub_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (output start, sub, a, b, c_in, input busy, done, sum, c_out, ovf);
    modport slave  (input start, sub, a, b, c_in, output busy, done, sum, c_out, ovf);
endinterface

// File: rtl/nibble_serial_addsub.sv
// WIDTH-bit add/sub that walks one DIGIT-bit lookahead group per clock,
// chaining the registered group carry into the next group.
module nibble_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input logic                   clk,
    input logic                   rst,
    nibble_serial_addsub_if.slave bus
);
    localparam int NG = WIDTH / DIGIT;
    localparam int CW = (NG > 1) ? $clog2(NG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NG - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic             accept, last;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] op_a, op_b, res, res_next;
    logic             carry;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_q, ovf_q;

    logic [DIGIT-1:0] ga, gb, g, p, gsum;
    logic [DIGIT:0]   c;
    logic             term, pchain;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = (cnt == LAST);
        unique case (state)
            IDLE: if (bus.start) begin
                accept     = 1'b1;
                state_next = RUN;
            end
            RUN: if (last) state_next = DONE;
            DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Each carry is expanded as a flat sum of products over the group, so no
    // carry depends on another carry inside the group.
    always_comb begin
        ga     = op_a[cnt*DIGIT +: DIGIT];
        gb     = op_b[cnt*DIGIT +: DIGIT];
        g      = ga & gb;
        p      = ga ^ gb;
        c      = '0;
        c[0]   = carry;
        term   = 1'b0;
        pchain = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            term   = g[i];
            pchain = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                term   = term | (pchain & g[j]);
                pchain = pchain & p[j];
            end
            c[i+1] = term | (pchain & c[0]);
        end
        gsum     = p ^ c[DIGIT-1:0];
        res_next = res;
        res_next[cnt*DIGIT +: DIGIT] = gsum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            op_a    <= '0;
            op_b    <= '0;
            res     <= '0;
            carry   <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            op_a  <= bus.a;
            op_b  <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub ? 1'b1 : bus.c_in;
        end else if (state == RUN) begin
            res   <= res_next;
            carry <= c[DIGIT];
            cnt   <= cnt + CW'(1);
            // Results are published only as the last group lands.
            if (last) begin
                sum_q   <= res_next;
                c_out_q <= c[DIGIT];
                ovf_q   <= c[DIGIT] ^ c[DIGIT-1];
            end
        end
    end

    assign bus.busy  = (state == RUN);
    assign bus.done  = (state == DONE);
    assign bus.sum   = sum_q;
    assign bus.c_out = c_out_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: doc/nibble_serial_addsub.md
# nibble_serial_addsub

Multi-cycle WIDTH-bit adder/subtractor that processes one DIGIT-bit group per clock. Each group's sum is formed with 4-bit carry-lookahead: per-bit generate/propagate, then group carries. The group carry-out is registered and fed into the next group. This block is the sequential consumer of the lookahead carry network: where the combinational tree merges group G/P upward and distributes carries downward, this block walks the groups over time through a start/busy/done handshake. It serves datapath units that trade latency for area.

## Interface
Parameters:
- WIDTH, 16: operand and result width. Must be a multiple of DIGIT.
- DIGIT, 4: bits processed per cycle, which is the lookahead group size.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request an operation. Sampled only when not busy.
- sub  in  1  0 = a+b+c_in; 1 = a−b (c_in ignored).
- a  in  WIDTH  operand A, captured on accepted start.
- b  in  WIDTH  operand B, captured on accepted start.
- c_in  in  1  carry-in for add, captured on accepted start.
- busy  out  1  high while groups are being processed.
- done  out  1  one-cycle pulse when results are updated.
- sum  out  WIDTH  result, held until the next completion.
- c_out  out  1  carry out of MSB; for sub, 1 = no borrow.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE; busy=0, done=0, sum=0, c_out=0, ovf=0, internal registers cleared.
- IDLE: if start=1, the block captures a and the effective b, and loads the group counter with 0.
  - Effective b is b when sub=0, ~b when sub=1.
  - Carry register loads c_in when sub=0, 1 when sub=1.
  - Next state is RUN.
- RUN: each cycle takes group k = bits [k·DIGIT +: DIGIT] of the captured operands.
  - g = a&b and p = a^b per bit.
  - Lookahead carries c[i+1] = g[i] | p[i]&c[i], with c[0] = carry register.
  - Group sum = p ^ c.
  - Group sum is written into the internal result register at slice k. The carry register takes the group carry-out. Counter increments.
  - On the last group (k = WIDTH/DIGIT−1), also capture the carry into the MSB for ovf, then go to DONE.
- DONE: copy result, final carry, and overflow to sum/c_out/ovf; done=1.
  - If start=1 in this state, the new operands are accepted exactly as in IDLE and the next state is RUN. Otherwise the next state is IDLE.
- start while in RUN is ignored; no queuing.
- sum/c_out/ovf change only on entry into DONE. Partial results are never visible.
- Arithmetic is modulo 2^WIDTH with no sign extension. Signed and unsigned interpretation differ only in the meaning of c_out and ovf.

## Timing
- With start high in cycle T (block idle):
  - busy=1 in cycles T+1 … T+WIDTH/DIGIT (4 cycles at defaults).
  - done=1 and new sum/c_out/ovf first visible in cycle T+WIDTH/DIGIT+1 (T+5).
- Latency is WIDTH/DIGIT+1 cycles from start to done.
- Throughput is one operation per WIDTH/DIGIT+1 cycles when start is held high.
- busy and done are never high in the same cycle.
- done is a single-cycle pulse.
- Outputs hold their values indefinitely after done until the next completion or a reset.
- Reset asserted in any cycle, including mid-RUN, has these effects from the next edge:
  - All outputs take their reset values and the state is IDLE.
  - The in-flight operation is discarded with no done pulse.
  - start is ignored in a cycle where rst=1.
- Operands and sub may change freely after the accepting edge. Only captured values are used.

## Test plan
- Add, c_in=0: a=0x1234, b=0x4321 with start in cycle T → busy during T+1..T+4; done in T+5 with sum=0x5555, c_out=0, ovf=0.
- Full carry ripple across all groups: a=0xFFFF, b=0x0001, c_in=0 → sum=0x0000, c_out=1, ovf=0. Separately a=0xFFFF, b=0x0000, c_in=1 gives the same result.
- Signed overflow on add: a=0x7FFF, b=0x0001 → sum=0x8000, c_out=0, ovf=1.
- Subtract:
  - a=0x0005, b=0x0007, sub=1 → sum=0xFFFE, c_out=0, ovf=0.
  - a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, c_out=1, ovf=1.
  - c_in=1 does not alter either result.
- Handshake/back-to-back: start held high with operands changed each cycle → only operands at T and T+5 are accepted. done pulses at T+5 and T+10. A start pulse at T+2 alone has no effect.
- Reset mid-operation: start at T, rst=1 in T+2 → from T+3 busy=0, done=0, sum=0, and no done pulse follows. A new start at T+4 completes normally with done at T+9.
